// File: rtl/wtf_audio_pkg.sv
// Shared types and default constants for the audio chain (FIR, decimator/FIFO, FFT).
package wtf_audio_pkg;

  localparam int SAMPLE_W           = 16;
  localparam int DECIM_DEFAULT      = 4;
  localparam int FIFO_DEPTH_DEFAULT = 16;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head output, separate occupancy counter and drop indication.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_MAX = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic             do_push;
  logic             do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CNT_MAX);
  assign do_pop  = pop && valid;
  // A pop frees the slot on the same edge, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);
  assign drop    = push && !do_push;
  assign rd_next = rd_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_next;
      count <= count + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
      // Head register: refill from memory on pop, or bypass din when the
      // incoming sample becomes the new head.
      if (do_pop) begin
        if (count == CNT_ONE) begin
          if (do_push) head <= din;
        end else begin
          head <= mem[rd_next];
        end
      end else if (do_push && !valid) begin
        head <= din;
      end
    end
  end

endmodule

// File: rtl/fir_decim_fifo.sv
// Keeps every DECIM-th FIR output sample and buffers it for a valid/ready consumer.
module fir_decim_fifo
  import wtf_audio_pkg::*;
#(
  parameter int DECIM = DECIM_DEFAULT,
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  input  logic signed [15:0]     data_in,
  input  logic                   phase_reset,
  input  logic                   clear_ovf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [15:0]     out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   overflow
);

  localparam int PHASE_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [PHASE_W-1:0] PHASE_LAST    = PHASE_W'(DECIM - 1);
  localparam logic [PHASE_W-1:0] PHASE_RESTART = (DECIM == 1) ? '0 : PHASE_W'(1);

  logic [PHASE_W-1:0] phase;
  logic               keep;
  logic               drop;
  logic [15:0]        head;

  // A phase_reset sample counts as phase 0 regardless of the counter.
  assign keep     = valid_in && (phase_reset || (phase == '0));
  assign out_data = head;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase <= '0;
    end else if (valid_in) begin
      if (phase_reset)              phase <= PHASE_RESTART;
      else if (phase == PHASE_LAST) phase <= '0;
      else                          phase <= phase + PHASE_W'(1);
    end else if (phase_reset) begin
      phase <= '0;
    end
  end

  // Set wins over clear when both happen on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n)         overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
    else if (clear_ovf) overflow <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (keep),
    .din   (data_in),
    .pop   (out_ready),
    .valid (out_valid),
    .head  (head),
    .count (count),
    .full  (full),
    .drop  (drop)
  );

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed bench for fir_decim_fifo: a DECIM=4 instance and a DECIM=1 instance with scoreboards.
module tb_fir_decim_fifo;
  import wtf_audio_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DECIM=4, DEPTH=16
  logic        rst_n_a = 1'b0, valid_a = 1'b0, pr_a = 1'b0, clr_a = 1'b0, ready_a = 1'b0;
  logic signed [15:0] data_a = '0;
  logic        out_valid_a, full_a, ovf_a;
  logic signed [15:0] out_data_a;
  logic [4:0]  count_a;

  // Instance B: DECIM=1, DEPTH=16
  logic        rst_n_b = 1'b0, valid_b = 1'b0, pr_b = 1'b0, clr_b = 1'b0, ready_b = 1'b0;
  logic signed [15:0] data_b = '0;
  logic        out_valid_b, full_b, ovf_b;
  logic signed [15:0] out_data_b;
  logic [4:0]  count_b;

  fir_decim_fifo #(.DECIM(4), .DEPTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .valid_in(valid_a), .data_in(data_a),
    .phase_reset(pr_a), .clear_ovf(clr_a), .out_valid(out_valid_a),
    .out_ready(ready_a), .out_data(out_data_a), .count(count_a),
    .full(full_a), .overflow(ovf_a)
  );

  fir_decim_fifo #(.DECIM(1), .DEPTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .valid_in(valid_b), .data_in(data_b),
    .phase_reset(pr_b), .clear_ovf(clr_b), .out_valid(out_valid_b),
    .out_ready(ready_b), .out_data(out_data_b), .count(count_b),
    .full(full_b), .overflow(ovf_b)
  );

  sample_t sb_a[$];
  sample_t sb_b[$];
  sample_t exp_a, exp_b;
  int npass = 0;
  int total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance n clock edges; directed steps always resume 1 time unit after an edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_a(input int d, input bit pr);
    valid_a = 1'b1; data_a = 16'(d); pr_a = pr;
    cyc(1);
    valid_a = 1'b0; pr_a = 1'b0;
    cyc(3);
  endtask

  // Scoreboard monitors: a handshake seen at the negedge completes at the next posedge.
  always @(negedge clk) begin
    if (out_valid_a && ready_a) begin
      check("a_sb_nonempty", 32'(sb_a.size() != 0), 32'd1);
      if (sb_a.size() != 0) begin
        exp_a = sb_a.pop_front();
        check("a_out_data", out_data_a, exp_a);
      end
    end
    if (out_valid_b && ready_b) begin
      check("b_sb_nonempty", 32'(sb_b.size() != 0), 32'd1);
      if (sb_b.size() != 0) begin
        exp_b = sb_b.pop_front();
        check("b_out_data", out_data_b, exp_b);
      end
    end
  end

  initial begin
    // Reset values
    cyc(2);
    check("rst_a_valid", out_valid_a, 0);
    check("rst_a_data",  out_data_a, 0);
    check("rst_a_count", count_a, 0);
    check("rst_a_full",  full_a, 0);
    check("rst_a_ovf",   ovf_a, 0);
    check("rst_b_valid", out_valid_b, 0);
    check("rst_b_count", count_b, 0);
    check("rst_b_ovf",   ovf_b, 0);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    cyc(1);

    // Decimation by 4 with one-cycle latency
    ready_a = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      valid_a = 1'b1; data_a = 16'(i);
      if (i % 4 == 1) sb_a.push_back(sample_t'(i));
      cyc(1);
      valid_a = 1'b0;
      @(negedge clk);
      check("lat_valid", out_valid_a, 32'(i % 4 == 1));
      if (i % 4 == 1) check("lat_data", out_data_a, i);
      cyc(31);
      check("cnt_zero", count_a, 0);
    end
    check("sb_a_empty1", sb_a.size(), 0);

    // phase_reset coincident with a sample
    sb_a.push_back(sample_t'(1));
    sb_a.push_back(sample_t'(100));
    sb_a.push_back(sample_t'(104));
    sb_a.push_back(sample_t'(108));
    for (int i = 1; i <= 3; i++) send_a(i, 1'b0);
    send_a(100, 1'b1);
    for (int i = 101; i <= 108; i++) send_a(i, 1'b0);
    check("sb_a_empty2", sb_a.size(), 0);

    // DECIM=1 fill past full with consumer stalled
    ready_b = 1'b0;
    for (int i = 0; i < 20; i++) begin
      valid_b = 1'b1; data_b = 16'(i);
      if (i < 16) sb_b.push_back(sample_t'(i));
      cyc(1);
      if (i == 14) check("b_not_full14", full_b, 0);
      if (i == 15) begin
        check("b_full16", full_b, 1);
        check("b_cnt16", count_b, 16);
        check("b_no_ovf16", ovf_b, 0);
      end
      if (i == 16) check("b_ovf_at16", ovf_b, 1);
    end
    valid_b = 1'b0;
    check("b_head0", out_data_b, 0);
    check("b_stall_stable", out_valid_b, 1);

    // Overflow clear, then clear coincident with a drop
    clr_b = 1'b1; cyc(1); clr_b = 1'b0;
    check("b_ovf_cleared", ovf_b, 0);
    clr_b = 1'b1; valid_b = 1'b1; data_b = 16'sd55;
    cyc(1);
    clr_b = 1'b0; valid_b = 1'b0;
    check("b_ovf_set_wins", ovf_b, 1);
    check("b_cnt_after_drop", count_b, 16);
    clr_b = 1'b1; cyc(1); clr_b = 1'b0;
    check("b_ovf_cleared2", ovf_b, 0);

    // Push and pop on a full FIFO
    ready_b = 1'b1; valid_b = 1'b1; data_b = 16'sd77;
    sb_b.push_back(sample_t'(77));
    cyc(1);
    valid_b = 1'b0;
    check("b_cnt_full_pp", count_b, 16);
    check("b_ovf_full_pp", ovf_b, 0);
    check("b_head1", out_data_b, 1);

    // Drain without bubbles
    for (int k = 0; k < 16; k++) begin
      check("b_no_bubble", out_valid_b, 1);
      cyc(1);
    end
    check("b_empty_valid", out_valid_b, 0);
    check("b_empty_cnt", count_b, 0);
    check("sb_b_empty", sb_b.size(), 0);

    // Mid-stream reset on instance A
    ready_a = 1'b0;
    pr_a = 1'b1; cyc(1); pr_a = 1'b0;
    for (int i = 0; i < 18; i++) begin
      valid_a = 1'b1; data_a = 16'(200 + i);
      cyc(1);
    end
    valid_a = 1'b0;
    check("a_mid_cnt5", count_a, 5);
    rst_n_a = 1'b0;
    cyc(1);
    rst_n_a = 1'b1;
    check("a_mrst_valid", out_valid_a, 0);
    check("a_mrst_cnt",   count_a, 0);
    check("a_mrst_data",  out_data_a, 0);
    ready_a = 1'b1; valid_a = 1'b1; data_a = 16'sd300;
    sb_a.push_back(sample_t'(300));
    cyc(1);
    valid_a = 1'b0;
    check("a_post_rst_valid", out_valid_a, 1);
    check("a_post_rst_data",  out_data_a, 300);
    cyc(2);
    check("sb_a_empty3", sb_a.size(), 0);

    $display("%0d/%0d checks passed", npass, total);
    $finish;
  end

endmodule
